// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-requester port selector: one-hot grant; prio names the port that wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 prio,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req0 && req1) begin
      grant = prio ? 2'b10 : 2'b01;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, one transaction outstanding at a time.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking (default: port 0 always wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic              rsp_err0,
  output logic              rsp_err1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [WORD_W-1:0] ReadAddress,
  output logic [WORD_W-1:0] WriteAddress,
  output logic [WORD_W-1:0] WriteData,
  input  logic [WORD_W-1:0] ReadData
);

  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * NUM_WORDS);

  state_t              state;
  state_t              state_next;
  logic [NUM_PORTS-1:0] pick;
  logic                prio;
  logic                any_req;
  logic                sel_we;
  logic [WORD_W-1:0]   sel_addr;
  logic [WORD_W-1:0]   sel_wdata;
  logic                addr_bad;
  logic [WORD_W-1:0]   rsp_data;

  logic                lat_we;
  logic                lat_port;
  logic                lat_err;
  logic [WORD_W-1:0]   lat_addr;
  logic [WORD_W-1:0]   lat_wdata;

  dmem_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .prio  (prio),
    .grant (pick)
  );

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= ~pick[1];
    end
  end

  assign prio = rr_ptr;
`else
  assign prio = 1'b0;
`endif

  always_comb begin
    any_req   = |pick;
    sel_we    = pick[1] ? we1    : we0;
    sel_addr  = pick[1] ? addr1  : addr0;
    sel_wdata = pick[1] ? wdata1 : wdata0;
    addr_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
    rsp_data  = (lat_we || lat_err) ? '0 : ReadData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        lat_we    <= sel_we;
        lat_port  <= pick[1];
        lat_err   <= addr_bad;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    rsp_err0   = 1'b0;
    rsp_err1   = 1'b0;
    rdata0     = '0;
    rdata1     = '0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          gnt0       = pick[0];
          gnt1       = pick[1];
          state_next = addr_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        MemRead    = ~lat_we;
        MemWrite   = lat_we;
        state_next = RESP;
      end
      RESP: begin
        if (lat_port) begin
          rsp_valid1 = 1'b1;
          rsp_err1   = lat_err;
          rdata1     = rsp_data;
        end else begin
          rsp_valid0 = 1'b1;
          rsp_err0   = lat_err;
          rdata0     = rsp_data;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset is synchronous, but strobes and responses must already be quiet
    // in the cycle it is asserted so an in-flight transaction is aborted cleanly.
    if (reset) begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      rsp_valid0 = 1'b0;
      rsp_valid1 = 1'b0;
      rsp_err0   = 1'b0;
      rsp_err1   = 1'b0;
      rdata0     = '0;
      rdata1     = '0;
    end
  end

  assign ReadAddress  = lat_addr;
  assign WriteAddress = lat_addr;
  assign WriteData    = lat_wdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 32, number of 32-bit words in the attached data memory; legal byte addresses are 0 to 4*NUM_WORDS-1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have ports req0/req1  input  1  per-requester access request, held until gnt.
REQ-005 SHALL have ports we0/we1  input  1  1=write, 0=read; valid while req high.
REQ-006 SHALL have ports addr0/addr1  input  32  byte address; valid while req high.
REQ-007 SHALL have ports wdata0/wdata1  input  32  write data; valid while req high.
REQ-008 SHALL have ports gnt0/gnt1  output  1  request accepted this cycle.
REQ-009 SHALL have ports rsp_valid0/rsp_valid1  output  1  one-cycle response strobe.
REQ-010 SHALL have ports rsp_err0/rsp_err1  output  1  response is an error; qualified by rsp_valid.
REQ-011 SHALL have ports rdata0/rdata1  output  32  read data; qualified by rsp_valid.
REQ-012 SHALL have memory-side ports MemRead, MemWrite  output  1; ReadAddress, WriteAddress, WriteData  output  32; ReadData  input  32 (valid the cycle after the edge that sampled MemRead).

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction outstanding at a time.
REQ-014 In IDLE with any req high, SHALL select one port, assert its gnt combinationally that cycle, and latch we/addr/wdata and port id at the edge.
REQ-015 Selection SHALL be fixed priority port 0 unless the round-robin feature (REQ-026) is compiled in.
REQ-016 gnt SHALL be asserted only in IDLE, to at most one port, and never to a port whose req is low.
REQ-017 Address with addr[1:0]!=0 or addr>=4*NUM_WORDS SHALL be an error: IDLE -> RESP directly, no MemRead/MemWrite pulse, rsp_err=1, rdata=0.
REQ-018 In ACCESS, SHALL drive exactly one of MemRead (read) or MemWrite (write) high for one cycle, with ReadAddress/WriteAddress = latched addr and WriteData = latched wdata.
REQ-019 Outside ACCESS, MemRead and MemWrite SHALL be 0; address/data outputs SHALL hold the latched values.
REQ-020 In RESP, SHALL assert rsp_valid for the granted port only, for one cycle; rdata = ReadData for reads, 0 for writes; rsp_err=0 for legal accesses.
REQ-021 Legal-access latency SHALL be: gnt in cycle N, MemRead/MemWrite in N+1, rsp_valid in N+2; next gnt no earlier than N+3.
REQ-022 Requests arriving outside IDLE SHALL be held by the requester and serviced in a later IDLE; none are dropped.
REQ-023 rdata/rsp_err for the non-responding port SHALL be 0.

Reset
REQ-024 reset SHALL force state IDLE, all gnt/rsp_valid/rsp_err/MemRead/MemWrite to 0, all address/data outputs and latched registers to 0, and the round-robin pointer to favour port 0.
REQ-025 reset asserted in ACCESS or RESP SHALL abort the transaction: no response is issued, and a memory strobe in that cycle SHALL be 0.

Configuration
REQ-026 With macro DMEM_ARB_RR_EN defined, selection SHALL be round-robin: after a grant to port p, port 1-p has priority on the next simultaneous request; without it, port 0 always wins ties.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP), WORD_W=32 and the port-count constant.
REQ-028 Port selection SHALL be a sub-module dmem_arb_pick (req0, req1, priority pointer in; one-hot grant out).

Verification
REQ-029 Port 0 write addr=0x08 data=0xDEADBEEF, then read 0x08 -> gnt0 cycle N, MemWrite N+1 with WriteAddress=0x08, rsp_valid0 N+2; read returns rdata0=0xDEADBEEF, rsp_err0=0.
REQ-030 req0 and req1 reads held high for 4 transactions -> without DMEM_ARB_RR_EN grants 0,0,0,0; with it 0,1,0,1.
REQ-031 Read addr=0x06 and read addr=0x80 (NUM_WORDS=32) -> rsp_err=1, rdata=0, rsp_valid two cycles after... one cycle after gnt, MemRead never pulsed.
REQ-032 reset asserted in ACCESS cycle of a write to 0x10 -> MemWrite=0 that cycle, no rsp_valid, later read of 0x10 returns prior contents.
REQ-033 Port 1 request raised during port 0 ACCESS -> gnt1 exactly at first IDLE after port 0 RESP, port 1 response correct.
